// File: rtl/mdu_unit.sv
// mdu_unit: execute-stage multiply/divide unit of the P7 MIPS pipeline.
// Owns HI/LO, runs MULT/MULTU/DIV/DIVU as fixed-latency operations behind
// busy, serves MFHI/MFLO combinationally on HL and handles MTHI/MTLO.
module mdu_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        start,
    output logic [31:0] HL,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      hi_q, lo_q;
    logic [31:0]      pend_hi_q, pend_lo_q;
    logic             pend_we_q;

    logic [31:0]      pend_hi_d, pend_lo_d;
    logic             pend_we_d;
    logic [CNT_W-1:0] cnt_load;

    logic [63:0]      prod_s, prod_u;
    logic             b_zero;
    logic [31:0]      abs_a, abs_b, dvsr_s, dvsr_u;
    logic [31:0]      uq_s, ur_s, uq_u, ur_u;

    // Result datapath: all four results computed from the current operands;
    // signed divide goes through magnitudes so 0x80000000 / -1 cannot overflow.
    always_comb begin
        prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u = {32'd0, A} * {32'd0, B};
        b_zero = (B == '0);
        abs_a  = A[31] ? (~A + 32'd1) : A;
        abs_b  = B[31] ? (~B + 32'd1) : B;
        dvsr_s = b_zero ? 32'd1 : abs_b;
        dvsr_u = b_zero ? 32'd1 : B;
        uq_s   = abs_a / dvsr_s;
        ur_s   = abs_a % dvsr_s;
        uq_u   = A / dvsr_u;
        ur_u   = A % dvsr_u;

        pend_hi_d = '0;
        pend_lo_d = '0;
        pend_we_d = 1'b1;
        cnt_load  = CNT_W'(DIV_CYCLES);
        case (op)
            OP_MULT: begin
                pend_hi_d = prod_s[63:32];
                pend_lo_d = prod_s[31:0];
                cnt_load  = CNT_W'(MULT_CYCLES);
            end
            OP_MULTU: begin
                pend_hi_d = prod_u[63:32];
                pend_lo_d = prod_u[31:0];
                cnt_load  = CNT_W'(MULT_CYCLES);
            end
            OP_DIV: begin
                pend_lo_d = (A[31] ^ B[31]) ? (~uq_s + 32'd1) : uq_s;
                pend_hi_d = A[31] ? (~ur_s + 32'd1) : ur_s;
                pend_we_d = ~b_zero;
            end
            OP_DIVU: begin
                pend_lo_d = uq_u;
                pend_hi_d = ur_u;
                pend_we_d = ~b_zero;
            end
            default: ;
        endcase
    end

    // Control FSM and architectural state: launch/MTxx only when idle and
    // not flushed; a busy op always runs to completion unless reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_we_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!Req) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                pend_hi_q <= pend_hi_d;
                                pend_lo_q <= pend_lo_d;
                                pend_we_q <= pend_we_d;
                                cnt_q     <= cnt_load;
                                state_q   <= S_BUSY;
                            end
                            OP_MTHI: hi_q <= A;
                            OP_MTLO: lo_q <= A;
                            default: ;
                        endcase
                    end
                end
                S_BUSY: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= S_IDLE;
                        if (pend_we_q) begin
                            hi_q <= pend_hi_q;
                            lo_q <= pend_lo_q;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Outputs: busy straight from the state register, HL read mux, start decode.
    always_comb begin
        busy  = (state_q == S_BUSY);
        start = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
        HI    = hi_q;
        LO    = lo_q;
        case (op)
            OP_MFHI: HL = hi_q;
            OP_MFLO: HL = lo_q;
            default: HL = '0;
        endcase
    end

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed-vector bench for mdu_unit with hand-computed results.
module tb_mdu_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        Req;
    logic [3:0]  op;
    logic [31:0] A, B;
    logic        busy, start;
    logic [31:0] HL, HI, LO;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .Req   (Req),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .start (start),
        .HL    (HL),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an op for one edge, then return to NONE.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic rq);
        op  = o;
        A   = a;
        B   = b;
        Req = rq;
        tick();
        op  = 4'd0;
        Req = 1'b0;
    endtask

    // Count cycles with busy high (bounded), compare to expected.
    task automatic wait_done(input string tag, input int unsigned exp_cycles);
        int unsigned n;
        n = 0;
        while (busy && n < 64) begin
            n++;
            tick();
        end
        chk(tag, 32'(n), 32'(exp_cycles));
    endtask

    initial begin
        reset = 1'b1; Req = 1'b0; op = 4'd0; A = '0; B = '0;
        tick();
        reset = 1'b0;
        chk("rst_hi", HI, 32'h0);
        chk("rst_lo", LO, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hl", HL, 32'h0);
        op = 4'd5; #1;
        chk("rst_mfhi", HL, 32'h0);
        op = 4'd0;

        // MULT -2 * 3
        op = 4'd1; A = 32'hFFFF_FFFE; B = 32'd3; #1;
        chk("start_mult", {31'd0, start}, 32'd1);
        issue(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        wait_done("mult_cycles", 5);
        chk("mult_hi", HI, 32'hFFFF_FFFF);
        chk("mult_lo", LO, 32'hFFFF_FFFA);

        // MULTU same operands
        issue(4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0);
        wait_done("multu_cycles", 5);
        chk("multu_hi", HI, 32'h0000_0002);
        chk("multu_lo", LO, 32'hFFFF_FFFA);

        // DIV -7 / 2
        issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_done("div_cycles", 10);
        chk("div_lo", LO, 32'hFFFF_FFFD);
        chk("div_hi", HI, 32'hFFFF_FFFF);

        // DIV overflow corner
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_done("divov_cycles", 10);
        chk("divov_lo", LO, 32'h8000_0000);
        chk("divov_hi", HI, 32'h0);

        // DIVU 100 / 7
        issue(4'd4, 32'd100, 32'd7, 1'b0);
        wait_done("divu_cycles", 10);
        chk("divu_lo", LO, 32'd14);
        chk("divu_hi", HI, 32'd2);

        // DIVU by zero leaves HI/LO alone
        issue(4'd7, 32'h11, 32'd0, 1'b0);
        issue(4'd8, 32'h11, 32'd0, 1'b0);
        chk("mthi_hi", HI, 32'h11);
        chk("mtlo_lo", LO, 32'h11);
        op = 4'd7; #1;
        chk("start_mthi", {31'd0, start}, 32'd0);
        op = 4'd0;
        issue(4'd4, 32'd7, 32'd0, 1'b0);
        wait_done("div0_cycles", 10);
        chk("div0_hi", HI, 32'h11);
        chk("div0_lo", LO, 32'h11);

        // Req cancels a launch and an MTLO
        issue(4'd1, 32'd2, 32'd3, 1'b1);
        chk("req_mult_busy", {31'd0, busy}, 32'd0);
        chk("req_mult_hi", HI, 32'h11);
        chk("req_mult_lo", LO, 32'h11);
        issue(4'd8, 32'h1234, 32'd0, 1'b1);
        chk("req_mtlo_lo", LO, 32'h11);

        // Req during an in-flight MULT does not disturb it
        issue(4'd1, 32'd2, 32'd3, 1'b0);
        tick();
        Req = 1'b1;
        tick();
        Req = 1'b0;
        chk("req_inflight_busy", {31'd0, busy}, 32'd1);
        wait_done("req_inflight_cycles", 3);
        chk("req_inflight_lo", LO, 32'd6);
        chk("req_inflight_hi", HI, 32'd0);

        // Reset in the middle of a DIV abandons it
        issue(4'd3, 32'd10, 32'd3, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstdiv_busy", {31'd0, busy}, 32'd0);
        chk("rstdiv_hi", HI, 32'h0);
        chk("rstdiv_lo", LO, 32'h0);
        for (int i = 0; i < 12; i++) tick();
        chk("rstdiv_late_hi", HI, 32'h0);
        chk("rstdiv_late_lo", LO, 32'h0);

        // MTHI then MFHI / MFLO
        issue(4'd7, 32'hDEAD_BEEF, 32'd0, 1'b0);
        op = 4'd5; #1;
        chk("mfhi_hl", HL, 32'hDEAD_BEEF);
        op = 4'd6; #1;
        chk("mflo_hl", HL, 32'h0);
        op = 4'd0; #1;
        chk("none_hl", HL, 32'h0);

        // Op presented while busy is ignored
        issue(4'd1, 32'd3, 32'd4, 1'b0);
        issue(4'd1, 32'd5, 32'd5, 1'b0);
        issue(4'd7, 32'h5555_5555, 32'd0, 1'b0);
        wait_done("ignore_cycles", 3);
        chk("ignore_lo", LO, 32'd12);
        chk("ignore_hi", HI, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
